sd_spi_arbiter: RTL and testbench

Sequences the SD card SPI link after power-up and shares it between a block-write engine and a block-read engine. Holds the bus for the init engine until init_end, then grants write/read requests round-robin. Each granted transfer gets a start pulse and a block address, and ends on the engine's busy fall or a timeout. Drives the single cs_n/mosi pair to the card. Fans miso out to all engines.

---
 rtl/sd_pkg.sv | 27 ++
 rtl/sd_rr_arbiter.sv | 33 +++
 rtl/sd_spi_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sd_spi_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card SPI link arbiter.
package sd_pkg;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned ADDR_W_DEF = 32;
    localparam logic [CNT_W-1:0] TIMEOUT_MAX_DEF = 24'd5_000_000;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WR_START,
        ST_WR_BUSY,
        ST_RD_START,
        ST_RD_BUSY
    } state_e;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    typedef struct packed {
        logic cs_n;
        logic mosi;
    } spi_bus_t;

endpackage

// File: rtl/sd_rr_arbiter.sv
// Two-way round-robin pick between pending write and read requests.
module sd_rr_arbiter
    import sd_pkg::*;
(
    input  logic   sys_clk,
    input  logic   sys_rst_n,
    input  logic   take,
    input  logic   wr_pend,
    input  logic   rd_pend,
    output logic   grant_vld_c,
    output grant_e grant_c
);

    grant_e last_grant;

    // On a tie, the channel not served last wins.
    always_comb begin
        grant_vld_c = wr_pend | rd_pend;
        grant_c     = GRANT_WR;
        if (rd_pend && (!wr_pend || last_grant == GRANT_WR)) begin
            grant_c = GRANT_RD;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_grant <= GRANT_RD;
        end else if (take && grant_vld_c) begin
            last_grant <= grant_c;
        end
    end

endmodule

// File: rtl/sd_spi_arbiter.sv
// Sequences the SD SPI link: init engine first, then round-robin shares
// the bus between the block-write and block-read engines with a timeout.
module sd_spi_arbiter
    import sd_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT_MAX = TIMEOUT_MAX_DEF,
    parameter int unsigned      ADDR_W      = ADDR_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              miso,
    output logic              eng_miso_c,
    output logic              cs_n,
    output logic              mosi,
    input  logic              init_cs_n,
    input  logic              init_mosi,
    input  logic              init_end,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              wr_start,
    output logic              rd_start,
    output logic [ADDR_W-1:0] eng_addr,
    input  logic              wr_busy,
    input  logic              rd_busy,
    input  logic              wr_cs_n,
    input  logic              wr_mosi,
    input  logic              rd_cs_n,
    input  logic              rd_mosi,
    output logic              wr_done,
    output logic              rd_done,
    output logic              err,
    output logic              err_rd,
    output logic              ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_MAX - CNT_W'(1);

    state_e            state, state_nxt;
    logic              wr_pend, wr_pend_nxt, rd_pend, rd_pend_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_q_nxt, rd_addr_q, rd_addr_q_nxt;
    logic [ADDR_W-1:0] eng_addr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              busy_seen, busy_seen_nxt;
    logic              wr_done_nxt, rd_done_nxt, err_nxt, err_rd_nxt;
    logic              in_rd, in_wr, x_busy, take;
    logic              grant_vld_c;
    grant_e            grant_c;
    spi_bus_t          bus;

    assign eng_miso_c = miso;
    assign in_wr  = (state == ST_WR_START) || (state == ST_WR_BUSY);
    assign in_rd  = (state == ST_RD_START) || (state == ST_RD_BUSY);
    assign x_busy = in_rd ? rd_busy : wr_busy;
    assign take   = (state == ST_IDLE) && init_end;

    sd_rr_arbiter u_rr (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .take        (take),
        .wr_pend     (wr_pend),
        .rd_pend     (rd_pend),
        .grant_vld_c (grant_vld_c),
        .grant_c     (grant_c)
    );

    always_comb begin
        state_nxt     = state;
        wr_pend_nxt   = wr_pend;
        rd_pend_nxt   = rd_pend;
        wr_addr_q_nxt = wr_addr_q;
        rd_addr_q_nxt = rd_addr_q;
        eng_addr_nxt  = eng_addr;
        cnt_nxt       = cnt;
        busy_seen_nxt = busy_seen;
        wr_done_nxt   = 1'b0;
        rd_done_nxt   = 1'b0;
        err_nxt       = 1'b0;
        err_rd_nxt    = 1'b0;

        // Capture a request unless that channel is already queued or running.
        if (state != ST_INIT) begin
            if (wr_req && !wr_pend && !in_wr) begin
                wr_pend_nxt   = 1'b1;
                wr_addr_q_nxt = wr_addr;
            end
            if (rd_req && !rd_pend && !in_rd) begin
                rd_pend_nxt   = 1'b1;
                rd_addr_q_nxt = rd_addr;
            end
        end

        unique case (state)
            ST_INIT: begin
                if (init_end) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (grant_vld_c) begin
                    cnt_nxt       = '0;
                    busy_seen_nxt = 1'b0;
                    if (grant_c == GRANT_RD) begin
                        rd_pend_nxt  = 1'b0;
                        eng_addr_nxt = rd_addr_q;
                        state_nxt    = ST_RD_START;
                    end else begin
                        wr_pend_nxt  = 1'b0;
                        eng_addr_nxt = wr_addr_q;
                        state_nxt    = ST_WR_START;
                    end
                end
            end
            ST_WR_START, ST_RD_START: begin
                cnt_nxt       = cnt + CNT_W'(1);
                busy_seen_nxt = busy_seen | x_busy;
                state_nxt     = in_rd ? ST_RD_BUSY : ST_WR_BUSY;
            end
            ST_WR_BUSY, ST_RD_BUSY: begin
                cnt_nxt       = cnt + CNT_W'(1);
                busy_seen_nxt = busy_seen | x_busy;
                if (busy_seen && !x_busy) begin
                    state_nxt   = ST_IDLE;
                    wr_done_nxt = !in_rd;
                    rd_done_nxt = in_rd;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = ST_IDLE;
                    err_nxt    = 1'b1;
                    err_rd_nxt = in_rd;
                end
            end
            default: state_nxt = ST_INIT;
        endcase

        // Losing init_end abandons everything silently.
        if (state != ST_INIT && !init_end) begin
            state_nxt   = ST_INIT;
            wr_pend_nxt = 1'b0;
            rd_pend_nxt = 1'b0;
            wr_done_nxt = 1'b0;
            rd_done_nxt = 1'b0;
            err_nxt     = 1'b0;
            err_rd_nxt  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_INIT;
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            eng_addr  <= '0;
            cnt       <= '0;
            busy_seen <= 1'b0;
            wr_start  <= 1'b0;
            rd_start  <= 1'b0;
            wr_done   <= 1'b0;
            rd_done   <= 1'b0;
            err       <= 1'b0;
            err_rd    <= 1'b0;
            ready     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_pend   <= wr_pend_nxt;
            rd_pend   <= rd_pend_nxt;
            wr_addr_q <= wr_addr_q_nxt;
            rd_addr_q <= rd_addr_q_nxt;
            eng_addr  <= eng_addr_nxt;
            cnt       <= cnt_nxt;
            busy_seen <= busy_seen_nxt;
            wr_start  <= (state_nxt == ST_WR_START);
            rd_start  <= (state_nxt == ST_RD_START);
            wr_done   <= wr_done_nxt;
            rd_done   <= rd_done_nxt;
            err       <= err_nxt;
            err_rd    <= err_rd_nxt;
            ready     <= (state_nxt == ST_IDLE);
        end
    end

    // Pad mux decodes only the registered state; reset forces the card deselected.
    always_comb begin
        bus = '{cs_n: 1'b1, mosi: 1'b1};
        unique case (state)
            ST_INIT:                 bus = '{cs_n: init_cs_n, mosi: init_mosi};
            ST_WR_START, ST_WR_BUSY: bus = '{cs_n: wr_cs_n, mosi: wr_mosi};
            ST_RD_START, ST_RD_BUSY: bus = '{cs_n: rd_cs_n, mosi: rd_mosi};
            default:                 bus = '{cs_n: 1'b1, mosi: 1'b1};
        endcase
        if (!sys_rst_n) bus = '{cs_n: 1'b1, mosi: 1'b1};
    end

    assign cs_n = bus.cs_n;
    assign mosi = bus.mosi;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed bench for sd_spi_arbiter: init muxing, grants, round-robin,
// timeout, ignored duplicate requests, init loss and async reset.
module tb_sd_spi_arbiter;

    localparam int unsigned ADDR_W = 32;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              miso, eng_miso_c, cs_n, mosi;
    logic              init_cs_n, init_mosi, init_end;
    logic              wr_req, rd_req;
    logic [ADDR_W-1:0] wr_addr, rd_addr, eng_addr;
    logic              wr_start, rd_start, wr_busy, rd_busy;
    logic              wr_cs_n, wr_mosi, rd_cs_n, rd_mosi;
    logic              wr_done, rd_done, err, err_rd, ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    sd_spi_arbiter #(.TIMEOUT_MAX(24'd1000), .ADDR_W(ADDR_W)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .miso(miso), .eng_miso_c(eng_miso_c),
        .cs_n(cs_n), .mosi(mosi), .init_cs_n(init_cs_n), .init_mosi(init_mosi),
        .init_end(init_end), .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req),
        .rd_addr(rd_addr), .wr_start(wr_start), .rd_start(rd_start), .eng_addr(eng_addr),
        .wr_busy(wr_busy), .rd_busy(rd_busy), .wr_cs_n(wr_cs_n), .wr_mosi(wr_mosi),
        .rd_cs_n(rd_cs_n), .rd_mosi(rd_mosi), .wr_done(wr_done), .rd_done(rd_done),
        .err(err), .err_rd(err_rd), .ready(ready)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sys_rst_n = 1'b0; miso = 1'b0;
        init_cs_n = 1'b0; init_mosi = 1'b0; init_end = 1'b0;
        wr_req = 1'b0; wr_addr = '0; rd_req = 1'b0; rd_addr = '0;
        wr_busy = 1'b0; rd_busy = 1'b0;
        wr_cs_n = 1'b1; wr_mosi = 1'b1; rd_cs_n = 1'b1; rd_mosi = 1'b1;

        // Reset values, pad held high even though init engine drives low
        tick(3);
        chk1("rst_cs_n", cs_n, 1'b1);
        chk1("rst_mosi", mosi, 1'b1);
        chk1("rst_ready", ready, 1'b0);
        chk32("rst_eng_addr", eng_addr, 32'h0);
        chk1("rst_pulses", |{wr_start, rd_start, wr_done, rd_done, err, err_rd}, 1'b0);
        miso = 1'b1; #1;
        chk1("miso_fan", eng_miso_c, 1'b1);
        miso = 1'b0;

        // INIT: pad follows init engine; a request here is dropped
        sys_rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 200; i++) begin
            init_mosi = i[0];
            wr_req    = (i == 50);
            wr_addr   = 32'h99;
            #1;
            chk1("init_mosi", mosi, i[0]);
            chk1("init_cs_n", cs_n, 1'b0);
            chk1("init_ready", ready, 1'b0);
            tick(1);
        end
        wr_req = 1'b0; wr_addr = '0;
        init_mosi = 1'b0; init_end = 1'b1;
        tick(1);
        chk1("init_done_ready", ready, 1'b1);
        chk1("idle_cs_n", cs_n, 1'b1);
        chk1("idle_mosi", mosi, 1'b1);
        tick(1);
        chk1("init_req_dropped_a", wr_start, 1'b0);
        tick(1);
        chk1("init_req_dropped_b", wr_start, 1'b0);
        chk1("idle_ready_hold", ready, 1'b1);

        // Single write, duplicate request during busy must be ignored
        wr_addr = 32'h10; wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0; wr_addr = '0;
        chk1("wr_start_early", wr_start, 1'b0);
        tick(1);
        chk1("wr_start", wr_start, 1'b1);
        chk32("wr_addr_10", eng_addr, 32'h10);
        chk1("wr_ready_low", ready, 1'b0);
        wr_cs_n = 1'b0; wr_mosi = 1'b0; #1;
        chk1("wr_cs_mux", cs_n, 1'b0);
        chk1("wr_mosi_mux", mosi, 1'b0);
        tick(1);
        chk1("wr_start_one", wr_start, 1'b0);
        wr_busy = 1'b1;
        tick(3);
        wr_addr = 32'h20; wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0; wr_addr = '0;
        tick(595);
        chk32("wr_addr_hold", eng_addr, 32'h10);
        chk1("wr_no_early_done", wr_done, 1'b0);
        wr_busy = 1'b0;
        tick(1);
        chk1("wr_done", wr_done, 1'b1);
        chk1("wr_done_ready", ready, 1'b1);
        chk1("wr_done_cs", cs_n, 1'b1);
        chk1("wr_done_err", err, 1'b0);
        tick(1);
        chk1("wr_done_one", wr_done, 1'b0);
        chk1("dup_ignored_a", wr_start, 1'b0);
        tick(1);
        chk1("dup_ignored_b", wr_start, 1'b0);
        wr_cs_n = 1'b1; wr_mosi = 1'b1;

        // Asynchronous reset in the middle of a transfer
        wr_addr = 32'h30; wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        tick(1);
        chk1("wr30_start", wr_start, 1'b1);
        wr_cs_n = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        chk1("async_rst_cs", cs_n, 1'b1);
        chk32("async_rst_addr", eng_addr, 32'h0);
        chk1("async_rst_start", wr_start, 1'b0);
        chk1("async_rst_ready", ready, 1'b0);
        tick(1);
        sys_rst_n = 1'b1; wr_cs_n = 1'b1;
        tick(1);
        chk1("rerst_ready", ready, 1'b1);

        // Simultaneous requests after reset: WR first, then RD
        wr_addr = 32'h40; rd_addr = 32'h50; wr_req = 1'b1; rd_req = 1'b1;
        tick(1);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(1);
        chk1("tie1_wr_start", wr_start, 1'b1);
        chk1("tie1_rd_wait", rd_start, 1'b0);
        chk32("tie1_addr", eng_addr, 32'h40);
        tick(1);
        wr_busy = 1'b1;
        tick(3);
        wr_busy = 1'b0;
        tick(1);
        chk1("tie1_wr_done", wr_done, 1'b1);
        chk1("tie1_rd_not_yet", rd_start, 1'b0);
        tick(1);
        chk1("tie1_rd_start", rd_start, 1'b1);
        chk32("tie1_rd_addr", eng_addr, 32'h50);
        chk1("tie1_wr_done_one", wr_done, 1'b0);
        rd_cs_n = 1'b0; rd_mosi = 1'b0; #1;
        chk1("rd_cs_mux", cs_n, 1'b0);
        chk1("rd_mosi_mux", mosi, 1'b0);
        tick(1);
        rd_busy = 1'b1;
        tick(2);
        rd_busy = 1'b0;
        tick(1);
        chk1("tie1_rd_done", rd_done, 1'b1);
        chk1("tie1_rd_err", err, 1'b0);
        rd_cs_n = 1'b1; rd_mosi = 1'b1;

        // Second tie: last grant was RD, so WR wins again
        wr_addr = 32'h41; rd_addr = 32'h51; wr_req = 1'b1; rd_req = 1'b1;
        tick(1);
        wr_req = 1'b0; rd_req = 1'b0;
        tick(1);
        chk1("tie2_wr_start", wr_start, 1'b1);
        chk1("tie2_rd_wait", rd_start, 1'b0);
        chk32("tie2_addr", eng_addr, 32'h41);
        tick(1);
        wr_busy = 1'b1;
        tick(2);
        wr_busy = 1'b0;
        tick(1);
        chk1("tie2_wr_done", wr_done, 1'b1);
        tick(1);
        chk1("tie2_rd_start", rd_start, 1'b1);
        chk32("tie2_rd_addr", eng_addr, 32'h51);

        // Read engine stuck busy: abort 1000 cycles after start
        rd_busy = 1'b1;
        tick(999);
        chk1("tmo_not_yet", err, 1'b0);
        tick(1);
        chk1("tmo_err", err, 1'b1);
        chk1("tmo_err_rd", err_rd, 1'b1);
        chk1("tmo_no_done", rd_done, 1'b0);
        chk1("tmo_ready", ready, 1'b1);
        tick(1);
        chk1("tmo_err_one", err, 1'b0);
        chk1("tmo_no_late_done", rd_done, 1'b0);
        rd_busy = 1'b0;

        // init_end lost during RD_BUSY with a write queued
        rd_addr = 32'h60; rd_req = 1'b1;
        tick(1);
        rd_req = 1'b0;
        tick(1);
        chk1("loss_rd_start", rd_start, 1'b1);
        chk32("loss_rd_addr", eng_addr, 32'h60);
        rd_cs_n = 1'b0; rd_mosi = 1'b0; init_cs_n = 1'b1; init_mosi = 1'b1;
        tick(1);
        rd_busy = 1'b1; wr_addr = 32'h70; wr_req = 1'b1;
        tick(1);
        wr_req = 1'b0;
        chk1("loss_rd_cs", cs_n, 1'b0);
        tick(2);
        init_end = 1'b0;
        tick(1);
        rd_cs_n = 1'b1; rd_mosi = 1'b1; init_cs_n = 1'b0; init_mosi = 1'b0; #1;
        chk1("loss_init_cs", cs_n, 1'b0);
        chk1("loss_init_mosi", mosi, 1'b0);
        chk1("loss_ready", ready, 1'b0);
        chk1("loss_no_done", rd_done, 1'b0);
        chk1("loss_no_err", err, 1'b0);
        rd_busy = 1'b0;
        tick(1);
        chk1("loss_no_done_b", rd_done, 1'b0);
        chk1("loss_no_err_b", err, 1'b0);
        init_cs_n = 1'b1; init_mosi = 1'b1; init_end = 1'b1;
        tick(1);
        chk1("reinit_ready", ready, 1'b1);
        tick(1);
        chk1("pend_cleared_wr", wr_start, 1'b0);
        chk1("pend_cleared_rd", rd_start, 1'b0);
        tick(1);
        chk1("pend_cleared_wr_b", wr_start, 1'b0);
        chk1("pend_cleared_ready", ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
